// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the IF/ID/RR/EX/MEM/WB pipeline:
// forwarding selects, load-use stalls, redirect flushes, memory-wait freezes.
module hazard_ctrl #(
  parameter int REG_W       = 3,
  parameter int LDSTALL_CYC = 1,
  parameter int FLUSH_CYC   = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rr_valid,
  input  logic [REG_W-1:0] rr_src_a,
  input  logic [REG_W-1:0] rr_src_b,
  input  logic             rr_use_a,
  input  logic             rr_use_b,
  input  logic             ex_valid,
  input  logic             ex_wr,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             mem_valid,
  input  logic             mem_wr,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             wb_valid,
  input  logic             wb_wr,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             stall_front,
  output logic             bubble_rr_ex,
  output logic             flush_front,
  output logic             freeze_all,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LDSTALL, FLUSH, FREEZE} state_t;

  localparam logic [2:0] SLOAD = 3'(LDSTALL_CYC - 1);
  localparam logic [2:0] FLOAD = 3'(FLUSH_CYC - 1);

  state_t     state, state_nxt, ret, ret_nxt, eff;
  logic [2:0] scnt, scnt_nxt, fcnt, fcnt_nxt;
  logic       redir_pend, redir_pend_nxt;
  logic       hazard, redir, flush_evt;

  function automatic logic [1:0] fwd_sel(
    input logic             use_op,
    input logic [REG_W-1:0] src,
    input logic             exv, input logic exw, input logic exl,
    input logic [REG_W-1:0] exd,
    input logic             mv, input logic mw, input logic [REG_W-1:0] md,
    input logic             wv, input logic ww, input logic [REG_W-1:0] wd
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (use_op) begin
      if (exv && exw && !exl && src == exd)  sel = 2'd1;
      else if (mv && mw && src == md)        sel = 2'd2;
      else if (wv && ww && src == wd)        sel = 2'd3;
    end
    return sel;
  endfunction

  assign hazard = rr_valid && ex_valid && ex_wr && ex_load &&
                  ((rr_use_a && rr_src_a == ex_dest) || (rr_use_b && rr_src_b == ex_dest));

  always_comb begin
    state_nxt      = state;
    ret_nxt        = ret;
    scnt_nxt       = scnt;
    fcnt_nxt       = fcnt;
    redir_pend_nxt = redir_pend;
    stall_front    = 1'b0;
    bubble_rr_ex   = 1'b0;
    flush_front    = 1'b0;
    freeze_all     = 1'b0;
    flush_evt      = 1'b0;
    eff            = state;
    redir          = ex_redirect;
    // Leaving a freeze behaves as the interrupted state, with any held redirect
    if (state == FREEZE) begin
      eff   = ret;
      redir = ex_redirect | redir_pend;
    end
    if (!reset) begin
      state_nxt = RUN;
    end else if (mem_busy) begin
      freeze_all = 1'b1;
      state_nxt  = FREEZE;
      if (state != FREEZE) ret_nxt = state;
      if (ex_redirect) redir_pend_nxt = 1'b1;
    end else if (redir) begin
      flush_front    = 1'b1;
      flush_evt      = 1'b1;
      redir_pend_nxt = 1'b0;
      scnt_nxt       = 3'd0;
      if (FLUSH_CYC > 1) begin
        state_nxt = FLUSH;
        fcnt_nxt  = FLOAD;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      case (eff)
        LDSTALL: begin
          stall_front  = 1'b1;
          bubble_rr_ex = 1'b1;
          scnt_nxt     = scnt - 3'd1;
          state_nxt    = (scnt == 3'd1) ? RUN : LDSTALL;
        end
        FLUSH: begin
          flush_front = 1'b1;
          fcnt_nxt    = fcnt - 3'd1;
          state_nxt   = (fcnt == 3'd1) ? RUN : FLUSH;
        end
        default: begin
          state_nxt = RUN;
          if (hazard) begin
            stall_front  = 1'b1;
            bubble_rr_ex = 1'b1;
            if (LDSTALL_CYC > 1) begin
              state_nxt = LDSTALL;
              scnt_nxt  = SLOAD;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
    if (reset && !freeze_all) begin
      fwd_a_sel = fwd_sel(rr_use_a, rr_src_a, ex_valid, ex_wr, ex_load, ex_dest,
                          mem_valid, mem_wr, mem_dest, wb_valid, wb_wr, wb_dest);
      fwd_b_sel = fwd_sel(rr_use_b, rr_src_b, ex_valid, ex_wr, ex_load, ex_dest,
                          mem_valid, mem_wr, mem_dest, wb_valid, wb_wr, wb_dest);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= RUN;
      ret        <= RUN;
      scnt       <= 3'd0;
      fcnt       <= 3'd0;
      redir_pend <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      ret        <= ret_nxt;
      scnt       <= scnt_nxt;
      fcnt       <= fcnt_nxt;
      redir_pend <= redir_pend_nxt;
      if ((stall_front || freeze_all) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
